// File: rtl/multicycle_ctrl.sv
// Multi-cycle miniRV control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// req/ack memory handshakes, byte/half accesses and a sticky illegal/timeout trap.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit SUPPORT_BYTE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_op,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [2:0]  sext_op,
  output logic [3:0]  alu_op,
  output logic        b_sel,
  output logic [2:0]  br_op,
  output logic        dram_we,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        trap,
  output logic        trap_cause
);

  localparam logic [1:0] NPC_PC4     = 2'd0;
  localparam logic [1:0] NPC_JMP     = 2'd1;
  localparam logic [1:0] NPC_JALR    = 2'd2;
  localparam logic [1:0] RF_WSEL_ALU = 2'd0;
  localparam logic [1:0] RF_WSEL_RDO = 2'd1;
  localparam logic [1:0] RF_WSEL_PC4 = 2'd2;
  localparam logic [1:0] RF_WSEL_EXT = 2'd3;
  localparam logic [2:0] SEXT_I      = 3'd0;
  localparam logic [2:0] SEXT_S      = 3'd1;
  localparam logic [2:0] SEXT_B      = 3'd2;
  localparam logic [2:0] SEXT_U      = 3'd3;
  localparam logic [2:0] SEXT_J      = 3'd4;
  localparam logic [2:0] SEXT_MOVE   = 3'd5;
  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_SLT     = 4'd8;
  localparam logic [3:0] ALU_SLTU    = 4'd9;
  localparam logic       B_SEL_RS2   = 1'b0;
  localparam logic       B_SEL_EXT   = 1'b1;
  localparam logic [2:0] BR_NONE     = 3'd0;
  localparam logic [2:0] BR_EQ       = 3'd1;
  localparam logic [2:0] BR_NE       = 3'd2;
  localparam logic [2:0] BR_LT       = 3'd3;
  localparam logic [2:0] BR_GE       = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int            CW         = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam bit            TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_BR    = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } cls_t;

  state_t        r_state;
  state_t        w_next;
  cls_t          r_cls;
  cls_t          w_cls;
  logic [CW-1:0] r_cnt;
  logic          r_imem_req;
  logic          r_dmem_req;
  logic          r_dram_we;
  logic          r_trap;
  logic          r_trap_cause;
  logic [1:0]    r_npc_op;
  logic [1:0]    r_rf_wsel;
  logic [2:0]    r_sext_op;
  logic [3:0]    r_alu_op;
  logic          r_b_sel;
  logic [2:0]    r_br_op;
  logic [1:0]    r_mem_size;
  logic          r_mem_unsigned;

  logic [6:0]    w_opcode;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;
  logic          w_illegal;
  logic [1:0]    w_npc_op;
  logic [1:0]    w_rf_wsel;
  logic [2:0]    w_sext_op;
  logic [3:0]    w_alu_op;
  logic          w_b_sel;
  logic [2:0]    w_br_op;
  logic [1:0]    w_mem_size;
  logic          w_mem_unsigned;
  logic          w_wait;
  logic          w_timeout;
  logic          w_trap_cause;
  logic          w_unused;

  assign w_opcode = inst[6:0];
  assign w_f3     = inst[14:12];
  assign w_f7     = inst[31:25];
  assign w_unused = ^{inst[24:15], inst[11:7]};

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Only LW/SW are legal when sub-word accesses are not supported.
  function automatic logic mem_f3_bad(input logic [2:0] f3, input logic is_load);
    logic bad;
    if (is_load) begin
      bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    end else begin
      bad = f3[2] || (f3[1:0] == 2'b11);
    end
    return bad || (!SUPPORT_BYTE && (f3 != 3'b010));
  endfunction

  // Instruction decode into control fields and an illegal flag.
  always_comb begin
    w_illegal      = 1'b0;
    w_cls          = CLS_ALU;
    w_npc_op       = NPC_PC4;
    w_rf_wsel      = RF_WSEL_ALU;
    w_sext_op      = SEXT_I;
    w_alu_op       = ALU_ADD;
    w_b_sel        = B_SEL_RS2;
    w_br_op        = BR_NONE;
    w_mem_size     = w_f3[1:0];
    w_mem_unsigned = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_f7 == 7'b0000000) begin
          w_alu_op = alu_sel(w_f3, 1'b0);
        end else if ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) begin
          w_alu_op = alu_sel(w_f3, 1'b1);
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_I: begin
        w_b_sel = B_SEL_EXT;
        if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
          w_sext_op = SEXT_MOVE;
          if (w_f7 == 7'b0000000) begin
            w_alu_op = alu_sel(w_f3, 1'b0);
          end else if ((w_f7 == 7'b0100000) && (w_f3 == 3'b101)) begin
            w_alu_op = ALU_SRA;
          end else begin
            w_illegal = 1'b1;
          end
        end else begin
          w_alu_op = alu_sel(w_f3, 1'b0);
        end
      end
      OP_LOAD: begin
        w_cls          = CLS_LOAD;
        w_b_sel        = B_SEL_EXT;
        w_rf_wsel      = RF_WSEL_RDO;
        w_mem_unsigned = w_f3[2];
        w_illegal      = mem_f3_bad(w_f3, 1'b1);
      end
      OP_STORE: begin
        w_cls     = CLS_STORE;
        w_b_sel   = B_SEL_EXT;
        w_sext_op = SEXT_S;
        w_illegal = mem_f3_bad(w_f3, 1'b0);
      end
      OP_BRANCH: begin
        w_cls     = CLS_BR;
        w_sext_op = SEXT_B;
        w_alu_op  = ALU_SUB;
        w_npc_op  = NPC_JMP;
        case (w_f3)
          3'b000:  w_br_op = BR_EQ;
          3'b001:  w_br_op = BR_NE;
          3'b100:  w_br_op = BR_LT;
          3'b101:  w_br_op = BR_GE;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_sext_op = SEXT_U;
        w_b_sel   = B_SEL_EXT;
        w_rf_wsel = RF_WSEL_EXT;
      end
      OP_JAL: begin
        w_sext_op = SEXT_J;
        w_rf_wsel = RF_WSEL_PC4;
        w_npc_op  = NPC_JMP;
      end
      OP_JALR: begin
        w_b_sel   = B_SEL_EXT;
        w_rf_wsel = RF_WSEL_PC4;
        w_npc_op  = NPC_JALR;
        w_illegal = (w_f3 != 3'b000);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Acks only count while the matching request is actually asserted.
  assign w_wait    = ((r_state == S_FETCH) && r_imem_req && !imem_ack) ||
                     ((r_state == S_MEM) && r_dmem_req && !dmem_ack);
  assign w_timeout = TIMEOUT_EN && w_wait && (r_cnt == CNT_MAX);

  // Next-state selection.
  always_comb begin
    w_next       = r_state;
    w_trap_cause = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_imem_req && imem_ack) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_trap_cause = 1'b1;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_cls)
          CLS_BR:    w_next = S_FETCH;
          CLS_LOAD:  w_next = S_MEM;
          CLS_STORE: w_next = S_MEM;
          default:   w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (r_dmem_req && dmem_ack) begin
          w_next = (r_cls == CLS_STORE) ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_trap_cause = 1'b1;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter restarts whenever a new handshake phase begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (w_wait) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Requests and trap status are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dram_we    <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_cause <= 1'b0;
    end else begin
      r_imem_req   <= (w_next == S_FETCH);
      r_dmem_req   <= (w_next == S_MEM);
      r_dram_we    <= (w_next == S_MEM) && (r_cls == CLS_STORE);
      r_trap       <= (w_next == S_TRAP);
      r_trap_cause <= ((w_next == S_TRAP) && (r_state != S_TRAP)) ? w_trap_cause : r_trap_cause;
    end
  end

  // Decode fields latched once in DECODE and held through the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls          <= CLS_ALU;
      r_npc_op       <= NPC_PC4;
      r_rf_wsel      <= RF_WSEL_ALU;
      r_sext_op      <= SEXT_I;
      r_alu_op       <= ALU_ADD;
      r_b_sel        <= B_SEL_RS2;
      r_br_op        <= BR_NONE;
      r_mem_size     <= 2'b00;
      r_mem_unsigned <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_cls          <= w_cls;
      r_npc_op       <= w_npc_op;
      r_rf_wsel      <= w_rf_wsel;
      r_sext_op      <= w_sext_op;
      r_alu_op       <= w_alu_op;
      r_b_sel        <= w_b_sel;
      r_br_op        <= w_br_op;
      r_mem_size     <= w_mem_size;
      r_mem_unsigned <= w_mem_unsigned;
    end else begin
      r_cls          <= r_cls;
      r_npc_op       <= r_npc_op;
      r_rf_wsel      <= r_rf_wsel;
      r_sext_op      <= r_sext_op;
      r_alu_op       <= r_alu_op;
      r_b_sel        <= r_b_sel;
      r_br_op        <= r_br_op;
      r_mem_size     <= r_mem_size;
      r_mem_unsigned <= r_mem_unsigned;
    end
  end

  // Ack-qualified strobes are suppressed in a reset cycle so nothing commits mid-transaction.
  assign ir_we        = !rst && (r_state == S_FETCH) && r_imem_req && imem_ack;
  assign rf_we        = !rst && (r_state == S_WB);
  assign pc_we        = !rst && (((r_state == S_EXEC) && (r_cls == CLS_BR)) ||
                                 (r_state == S_WB) ||
                                 ((r_state == S_MEM) && r_dmem_req && dmem_ack && (r_cls == CLS_STORE)));
  assign dram_we      = !rst && r_dram_we;
  assign imem_req     = r_imem_req;
  assign dmem_req     = r_dmem_req;
  assign trap         = r_trap;
  assign trap_cause   = r_trap_cause;
  assign npc_op       = r_npc_op;
  assign rf_wsel      = r_rf_wsel;
  assign sext_op      = r_sext_op;
  assign alu_op       = r_alu_op;
  assign b_sel        = r_b_sel;
  assign br_op        = r_br_op;
  assign mem_size     = r_mem_size;
  assign mem_unsigned = r_mem_unsigned;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe expectations go through a
// queue, decode fields are checked at fixed points; three parameterisations share stimulus.
module tb_multicycle_ctrl;

  localparam logic [6:0] V_IREQ = 7'b1000000;
  localparam logic [6:0] V_DREQ = 7'b0100000;
  localparam logic [6:0] V_IRWE = 7'b0010000;
  localparam logic [6:0] V_PCWE = 7'b0001000;
  localparam logic [6:0] V_RFWE = 7'b0000100;
  localparam logic [6:0] V_DWE  = 7'b0000010;
  localparam logic [6:0] V_TRAP = 7'b0000001;
  localparam logic [6:0] V_NONE = 7'b0000000;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_LB   = 32'h00008103;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        imem_ack;
  logic        dmem_ack;

  logic m_imem_req, m_dmem_req, m_ir_we, m_pc_we, m_rf_we, m_dram_we, m_trap, m_trap_cause;
  logic [1:0] m_npc_op, m_rf_wsel, m_mem_size;
  logic [2:0] m_sext_op, m_br_op;
  logic [3:0] m_alu_op;
  logic       m_b_sel, m_mem_unsigned;

  logic n_imem_req, n_dmem_req, n_ir_we, n_pc_we, n_rf_we, n_dram_we, n_trap, n_trap_cause;
  logic t_imem_req, t_dmem_req, t_ir_we, t_pc_we, t_rf_we, t_dram_we, t_trap, t_trap_cause;
  logic [17:0] n_fields_unused;
  logic [17:0] t_fields_unused;

  logic [6:0] exp_q[$];
  int         sel;
  int         cyc_n;
  int         n_checks;
  int         n_fail;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(m_imem_req), .dmem_req(m_dmem_req), .ir_we(m_ir_we), .pc_we(m_pc_we),
    .npc_op(m_npc_op), .rf_we(m_rf_we), .rf_wsel(m_rf_wsel), .sext_op(m_sext_op),
    .alu_op(m_alu_op), .b_sel(m_b_sel), .br_op(m_br_op), .dram_we(m_dram_we),
    .mem_size(m_mem_size), .mem_unsigned(m_mem_unsigned), .trap(m_trap), .trap_cause(m_trap_cause)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(15), .SUPPORT_BYTE(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(n_imem_req), .dmem_req(n_dmem_req), .ir_we(n_ir_we), .pc_we(n_pc_we),
    .npc_op(n_fields_unused[17:16]), .rf_we(n_rf_we), .rf_wsel(n_fields_unused[15:14]),
    .sext_op(n_fields_unused[13:11]), .alu_op(n_fields_unused[10:7]), .b_sel(n_fields_unused[6]),
    .br_op(n_fields_unused[5:3]), .dram_we(n_dram_we), .mem_size(n_fields_unused[2:1]),
    .mem_unsigned(n_fields_unused[0]), .trap(n_trap), .trap_cause(n_trap_cause)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4), .SUPPORT_BYTE(1'b1)) dut_to (
    .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(t_imem_req), .dmem_req(t_dmem_req), .ir_we(t_ir_we), .pc_we(t_pc_we),
    .npc_op(t_fields_unused[17:16]), .rf_we(t_rf_we), .rf_wsel(t_fields_unused[15:14]),
    .sext_op(t_fields_unused[13:11]), .alu_op(t_fields_unused[10:7]), .b_sel(t_fields_unused[6]),
    .br_op(t_fields_unused[5:3]), .dram_we(t_dram_we), .mem_size(t_fields_unused[2:1]),
    .mem_unsigned(t_fields_unused[0]), .trap(t_trap), .trap_cause(t_trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] vec(input int s);
    case (s)
      1:       return {n_imem_req, n_dmem_req, n_ir_we, n_pc_we, n_rf_we, n_dram_we, n_trap};
      2:       return {t_imem_req, t_dmem_req, t_ir_we, t_pc_we, t_rf_we, t_dram_we, t_trap};
      default: return {m_imem_req, m_dmem_req, m_ir_we, m_pc_we, m_rf_we, m_dram_we, m_trap};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected strobes, compare mid-cycle.
  task automatic cyc(input logic r, input logic ia, input logic da, input logic [6:0] exp, input string tag);
    logic [6:0] e;
    rst      = r;
    imem_ack = ia;
    dmem_ack = da;
    exp_q.push_back(exp);
    #2;
    e = exp_q.pop_front();
    chk($sformatf("%s_c%0d", tag, cyc_n), {25'd0, vec(sel)}, {25'd0, e});
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("reset_vec", {25'd0, vec(sel)}, 32'd0);
    chk("reset_fields", {13'd0, m_npc_op, m_rf_wsel, m_sext_op, m_alu_op, m_b_sel, m_br_op,
                         m_mem_size, m_mem_unsigned, m_trap_cause}, 32'd0);
    cyc_n = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    cyc_n    = 0;
    rst      = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    inst     = I_ADDI;

    // addi: F D E W, then the next fetch
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "addi");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "addi");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "addi");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "addi");
    cyc(1'b0, 1'b0, 1'b0, V_PCWE | V_RFWE, "addi");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "addi");
    chk("addi_alu_op", {28'd0, m_alu_op}, 32'd0);
    chk("addi_b_sel", {31'd0, m_b_sel}, 32'd1);
    chk("addi_rf_wsel", {30'd0, m_rf_wsel}, 32'd0);
    chk("addi_sext_op", {29'd0, m_sext_op}, 32'd0);
    chk("addi_npc_op", {30'd0, m_npc_op}, 32'd0);

    // lw with dmem_ack three cycles late
    inst = I_LW;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "lw");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "lw");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "lw");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "lw");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, V_DREQ, "lw");
    cyc(1'b0, 1'b0, 1'b1, V_DREQ, "lw");
    cyc(1'b0, 1'b0, 1'b0, V_PCWE | V_RFWE, "lw");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "lw");
    chk("lw_rf_wsel", {30'd0, m_rf_wsel}, 32'd1);
    chk("lw_mem_size", {30'd0, m_mem_size}, 32'd2);
    chk("lw_mem_unsigned", {31'd0, m_mem_unsigned}, 32'd0);

    // sw with zero-wait ack
    inst = I_SW;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "sw");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "sw");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "sw");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "sw");
    cyc(1'b0, 1'b0, 1'b1, V_DREQ | V_DWE | V_PCWE, "sw");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "sw");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "sw");

    // rst arrives together with the store ack: no strobes, req drops next cycle
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "swrst");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "swrst");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "swrst");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "swrst");
    cyc(1'b1, 1'b0, 1'b1, V_DREQ, "swrst");
    cyc(1'b0, 1'b1, 1'b1, V_NONE, "swrst");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "swrst");

    // beq: F D E, pc_we in EXEC
    inst = I_BEQ;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "beq");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "beq");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "beq");
    cyc(1'b0, 1'b0, 1'b0, V_PCWE, "beq");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "beq");
    chk("beq_br_op", {29'd0, m_br_op}, 32'd1);
    chk("beq_alu_op", {28'd0, m_alu_op}, 32'd1);
    chk("beq_npc_op", {30'd0, m_npc_op}, 32'd1);

    // unknown opcode traps with cause 0; acks in TRAP are ignored
    inst = I_BAD;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "ill");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "ill");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "ill");
    cyc(1'b0, 1'b1, 1'b1, V_TRAP, "ill");
    cyc(1'b0, 1'b1, 1'b1, V_TRAP, "ill");
    chk("ill_cause", {31'd0, m_trap_cause}, 32'd0);
    inst = I_ADDI;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "recover");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "recover");

    // lb: illegal without byte support, legal on the default instance
    inst = I_LB;
    sel  = 1;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "lbnb");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "lbnb");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "lbnb");
    cyc(1'b0, 1'b0, 1'b0, V_TRAP, "lbnb");
    cyc(1'b0, 1'b0, 1'b0, V_TRAP, "lbnb");
    chk("lbnb_cause", {31'd0, n_trap_cause}, 32'd0);
    chk("lb_main_dmem_req", {31'd0, m_dmem_req}, 32'd1);
    chk("lb_main_trap", {31'd0, m_trap}, 32'd0);
    chk("lb_main_mem_size", {30'd0, m_mem_size}, 32'd0);

    // lw with no dmem_ack on MEM_TIMEOUT=4: five MEM cycles, then trap cause 1
    inst = I_LW;
    sel  = 2;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, V_NONE, "tmo");
    cyc(1'b0, 1'b1, 1'b0, V_IREQ | V_IRWE, "tmo");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "tmo");
    cyc(1'b0, 1'b0, 1'b0, V_NONE, "tmo");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, V_DREQ, "tmo");
    cyc(1'b0, 1'b0, 1'b0, V_TRAP, "tmo");
    cyc(1'b0, 1'b0, 1'b0, V_TRAP, "tmo");
    chk("tmo_cause", {31'd0, t_trap_cause}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
